// File: rtl/counter_regs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_regs_pkg                                                   |
// | Register map, CTRL bits, bus strobes and poll FSM states.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package counter_regs_pkg;

  localparam logic [31:0] OFF_CTRL  = 32'h0000_0000;
  localparam logic [31:0] OFF_LOAD  = 32'h0000_0004;
  localparam logic [31:0] OFF_VALUE = 32'h0000_0008;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIR_BIT = 1;

  localparam logic [3:0] WSTRB_WR = 4'hF;
  localparam logic [3:0] WSTRB_RD = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_LOAD = 3'd1,
    ST_WR_CTRL = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RD_VAL  = 3'd4,
    ST_WR_STOP = 3'd5
  } state_t;

  function automatic logic [31:0] ctrl_word(input logic i_en, input logic i_dir);
    logic [31:0] w_word;
    w_word               = '0;
    w_word[CTRL_EN_BIT]  = i_en;
    w_word[CTRL_DIR_BIT] = i_dir;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/native_bus_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | native_bus_initiator                                               |
// | Single read/write on the PicoRV32 native bus with hold and timeout.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module native_bus_initiator
  import counter_regs_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int            CW     = 10;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  logic          r_valid;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [CW-1:0] r_wait;

  assign o_done  = r_valid && mem_ready;
  assign o_err   = r_valid && !mem_ready && (r_wait == C_LAST);
  assign o_rdata = mem_rdata;

  // Request fields load only while idle, so they stay frozen under mem_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wait  <= '0;
    end else if (r_valid) begin
      if (o_done || o_err) begin
        r_valid <= 1'b0;
        r_wait  <= '0;
      end else begin
        r_wait  <= r_wait + 1'b1;
      end
    end else if (i_req) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_write ? i_wdata : 32'h0;
      r_wstrb <= i_write ? WSTRB_WR : WSTRB_RD;
      r_wait  <= '0;
    end
  end

  assign mem_valid = r_valid;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: rtl/counter_poll_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_poll_master                                                |
// | Programs the counter responder, then polls VALUE at an interval.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module counter_poll_master
  import counter_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT   = 64,
  parameter int          IVL_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      cfg_load,
  input  logic             cfg_dir,
  input  logic [IVL_W-1:0] cfg_interval,
  input  logic [31:0]      cfg_threshold,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic [31:0]      sample,
  output logic             sample_valid,
  output logic             hit,
  output logic             bus_err
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_after;
  logic             r_stop_pend;
  logic             r_dir;
  logic [31:0]      r_load;
  logic [31:0]      r_thr;
  logic [IVL_W-1:0] r_ivl;
  logic [IVL_W-1:0] r_wait_cnt;
  logic [31:0]      r_sample;
  logic             r_sample_valid;
  logic             r_hit;
  logic             r_bus_err;

  logic             w_req;
  logic             w_write;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_done;
  logic             w_err;
  logic [31:0]      w_rdata;
  logic             w_stop_any;
  logic [IVL_W-1:0] w_ivl_last;

  assign w_stop_any = r_stop_pend || stop;
  // A zero interval waits one cycle, same as an interval of one.
  assign w_ivl_last = (r_ivl == '0) ? '0 : r_ivl - IVL_W'(1);

  always_comb begin
    w_next  = r_state;
    w_after = ST_IDLE;
    w_req   = 1'b0;
    w_write = 1'b1;
    w_addr  = BASE_ADDR + OFF_LOAD;
    w_wdata = r_load;

    case (r_state)
      ST_IDLE:    w_wdata = cfg_load;
      ST_WR_LOAD: w_after = w_stop_any ? ST_WR_STOP : ST_WR_CTRL;
      ST_WR_CTRL: begin
        w_addr  = BASE_ADDR + OFF_CTRL;
        w_wdata = ctrl_word(1'b1, r_dir);
        w_after = w_stop_any ? ST_WR_STOP : ST_WAIT;
      end
      ST_RD_VAL: begin
        w_addr  = BASE_ADDR + OFF_VALUE;
        w_wdata = '0;
        w_write = 1'b0;
        w_after = w_stop_any ? ST_WR_STOP : ST_WAIT;
      end
      ST_WR_STOP: begin
        w_addr  = BASE_ADDR + OFF_CTRL;
        w_wdata = ctrl_word(1'b0, 1'b0);
      end
      default: ;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_WR_LOAD;
          w_req  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_stop_any)                     w_next = ST_WR_STOP;
        else if (r_wait_cnt == w_ivl_last)  w_next = ST_RD_VAL;
      end
      ST_WR_LOAD, ST_WR_CTRL, ST_RD_VAL, ST_WR_STOP: begin
        if (w_err) begin
          w_next = ST_IDLE;
        end else if (w_done) begin
          w_next = w_after;
        end else if (!mem_valid) begin
          // Nothing in flight yet: a pending stop skips this access.
          if (w_stop_any && (r_state != ST_WR_STOP)) w_next = ST_WR_STOP;
          else                                       w_req  = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_stop_pend    <= 1'b0;
      r_dir          <= 1'b0;
      r_load         <= '0;
      r_thr          <= '0;
      r_ivl          <= '0;
      r_wait_cnt     <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_sample_valid <= 1'b0;

      if (r_state == ST_IDLE) begin
        r_stop_pend <= 1'b0;
        if (start) begin
          r_load    <= cfg_load;
          r_dir     <= cfg_dir;
          r_ivl     <= cfg_interval;
          r_thr     <= cfg_threshold;
          r_hit     <= 1'b0;
          r_bus_err <= 1'b0;
        end
      end else if (stop) begin
        r_stop_pend <= 1'b1;
      end

      if (w_err) r_bus_err <= 1'b1;

      if ((r_state == ST_RD_VAL) && w_done) begin
        r_sample       <= w_rdata;
        r_sample_valid <= 1'b1;
        if (w_rdata == r_thr) r_hit <= 1'b1;
      end

      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + IVL_W'(1) : '0;
    end
  end

  native_bus_initiator #(
    .TIMEOUT (TIMEOUT)
  ) u_bus (
    .clk       (clk),
    .reset     (reset),
    .i_req     (w_req),
    .i_write   (w_write),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .o_done    (w_done),
    .o_err     (w_err),
    .o_rdata   (w_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  assign busy         = (r_state != ST_IDLE);
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign hit          = r_hit;
  assign bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_poll_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_counter_poll_master                                             |
// | Directed bench with a scripted native-bus counter responder.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_counter_poll_master;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_load = '0;
  logic        cfg_dir = 1'b0;
  logic [15:0] cfg_interval = '0;
  logic [31:0] cfg_threshold = '0;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [31:0] sample;
  logic        sample_valid;
  logic        hit;
  logic        bus_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // responder controls and transaction log
  int          resp_wait = 0;
  bit          resp_hang = 1'b0;
  logic [31:0] rd_val = '0;
  logic [31:0] rd_step = 32'd1;
  int          log_n = 0, rd_n = 0, samp_n = 0;
  logic [31:0] log_addr [64];
  logic [31:0] log_wdata[64];
  logic [3:0]  log_wstrb[64];
  int          log_vcyc [64];
  int          log_ccyc [64];
  int          log_vcnt [64];
  int          rd_cc    [64];
  logic [31:0] samp     [64];
  int          samp_cyc [64];
  logic        samp_hit [64];
  int          unstable_cnt = 0, b2b_cnt = 0, drop_len = 0, valid_starts = 0;

  counter_poll_master #(
    .BASE_ADDR (BASE),
    .TIMEOUT   (8),
    .IVL_W     (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .cfg_load      (cfg_load),
    .cfg_dir       (cfg_dir),
    .cfg_interval  (cfg_interval),
    .cfg_threshold (cfg_threshold),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .hit           (hit),
    .bus_err       (bus_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Responder: drives mem_ready/mem_rdata from the falling edge.
  initial begin : responder
    int          wcnt;
    int          vcyc;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;
    wcnt = 0; vcyc = 0; h_addr = '0; h_wdata = '0; h_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        if (mem_valid) b2b_cnt++;
        mem_ready = 1'b0;
        mem_rdata = 32'hA5A5_A5A5;
        wcnt = 0;
      end else if (mem_valid) begin
        if (wcnt == 0) begin
          h_addr = mem_addr; h_wdata = mem_wdata; h_wstrb = mem_wstrb;
          vcyc = cyc; valid_starts++;
        end else if (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_wstrb !== h_wstrb) begin
          unstable_cnt++;
        end
        if (!resp_hang && wcnt >= resp_wait && log_n < 64) begin
          mem_ready = 1'b1;
          log_addr[log_n] = mem_addr; log_wdata[log_n] = mem_wdata;
          log_wstrb[log_n] = mem_wstrb; log_vcyc[log_n] = vcyc;
          log_ccyc[log_n] = cyc; log_vcnt[log_n] = wcnt + 1;
          log_n++;
          if (mem_wstrb == 4'h0 && rd_n < 64) begin
            mem_rdata = rd_val;
            rd_val = rd_val + rd_step;
            rd_cc[rd_n] = cyc;
            rd_n++;
          end
        end
        wcnt++;
      end else begin
        if (wcnt != 0) drop_len = wcnt;
        wcnt = 0;
      end
    end
  end

  initial begin : sample_monitor
    forever begin
      @(negedge clk);
      if (sample_valid && samp_n < 64) begin
        samp[samp_n] = sample; samp_cyc[samp_n] = cyc; samp_hit[samp_n] = hit;
        samp_n++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs;
    log_n = 0; rd_n = 0; samp_n = 0;
    unstable_cnt = 0; b2b_cnt = 0; drop_len = 0; valid_starts = 0;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop;
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < lim) begin @(negedge clk); t++; end
    ok = (busy === 1'b0);
  endtask

  task automatic wait_samples(input int n, input int lim, output bit ok);
    int t;
    t = 0;
    while (samp_n < n && t < lim) begin @(negedge clk); t++; end
    ok = (samp_n >= n);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_valid, busy, sample_valid, hit, bus_err, sample, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b busy=%b sv=%b hit=%b err=%b smp=%h addr=%h wd=%h ws=%h want all 0",
               mem_valid, busy, sample_valid, hit, bus_err, sample, mem_addr, mem_wdata, mem_wstrb);
    end
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic test_basic;
    int  s_cyc;
    bit  ok;
    resp_wait = 0; resp_hang = 1'b0; rd_val = 32'd101; rd_step = 32'd1;
    cfg_load = 32'd100; cfg_dir = 1'b1; cfg_interval = 16'd4; cfg_threshold = 32'hFFFF_FFFF;
    @(negedge clk); start = 1'b1; s_cyc = cyc;
    @(negedge clk); start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_samples(3, 300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_samples: got %0d samples want 3", samp_n); end
    total++;
    if (log_vcyc[0] !== s_cyc + 1) begin
      bad++; $display("FAIL start_latency: got cycle %0d want %0d", log_vcyc[0], s_cyc + 1);
    end
    total++;
    if (log_addr[0] !== BASE + 32'h4 || log_wdata[0] !== 32'd100 || log_wstrb[0] !== 4'hF) begin
      bad++; $display("FAIL wr_load: got %h/%h/%h want %h/00000064/f", log_addr[0], log_wdata[0], log_wstrb[0], BASE + 32'h4);
    end
    total++;
    if (log_addr[1] !== BASE || log_wdata[1] !== 32'h3 || log_wstrb[1] !== 4'hF) begin
      bad++; $display("FAIL wr_ctrl: got %h/%h/%h want %h/00000003/f", log_addr[1], log_wdata[1], log_wstrb[1], BASE);
    end
    total++;
    if (log_addr[2] !== BASE + 32'h8 || log_wdata[2] !== 32'h0 || log_wstrb[2] !== 4'h0) begin
      bad++; $display("FAIL rd_value: got %h/%h/%h want %h/00000000/0", log_addr[2], log_wdata[2], log_wstrb[2], BASE + 32'h8);
    end
    total++;
    if (log_vcyc[3] - log_vcyc[2] < 5 || log_vcyc[4] - log_vcyc[3] < 5) begin
      bad++; $display("FAIL poll_spacing: got %0d,%0d want >=5", log_vcyc[3] - log_vcyc[2], log_vcyc[4] - log_vcyc[3]);
    end
    total++;
    if (samp[0] !== 32'd101 || samp[1] !== 32'd102 || samp[2] !== 32'd103) begin
      bad++; $display("FAIL samples_up: got %0d,%0d,%0d want 101,102,103", samp[0], samp[1], samp[2]);
    end
    total++;
    if (samp_cyc[0] !== rd_cc[0] + 1 || samp_cyc[1] !== rd_cc[1] + 1) begin
      bad++; $display("FAIL sample_latency: got %0d,%0d want %0d,%0d", samp_cyc[0], samp_cyc[1], rd_cc[0] + 1, rd_cc[1] + 1);
    end
    pulse_stop();
    wait_idle(100, ok);
    total++;
    if (!ok || log_addr[log_n-1] !== BASE || log_wdata[log_n-1] !== 32'h0 || log_wstrb[log_n-1] !== 4'hF) begin
      bad++; $display("FAIL basic_stop: got idle=%b last=%h/%h want idle=1 last=%h/00000000", ok, log_addr[log_n-1], log_wdata[log_n-1], BASE);
    end
  endtask

  task automatic test_wait_states;
    bit ok;
    clear_logs();
    resp_wait = 3; rd_val = 32'd50; rd_step = 32'd1;
    cfg_load = 32'h0000_1234; cfg_dir = 1'b1; cfg_interval = 16'd2;
    pulse_start();
    wait_samples(2, 400, ok);
    total++;
    if (!ok || log_vcnt[0] !== 4 || log_vcnt[1] !== 4 || log_vcnt[2] !== 4) begin
      bad++; $display("FAIL wait_valid_len: got %0d,%0d,%0d want 4,4,4", log_vcnt[0], log_vcnt[1], log_vcnt[2]);
    end
    total++;
    if (unstable_cnt !== 0) begin bad++; $display("FAIL hold_stable: got %0d changes want 0", unstable_cnt); end
    total++;
    if (log_vcyc[1] !== log_ccyc[0] + 2 || b2b_cnt !== 0) begin
      bad++; $display("FAIL idle_gap: got next=%0d b2b=%0d want %0d b2b=0", log_vcyc[1], b2b_cnt, log_ccyc[0] + 2);
    end
    pulse_stop();
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wait_stop_idle: got busy=%b want 0", busy); end
    resp_wait = 0;
  endtask

  task automatic test_timeout;
    int t;
    int vs0;
    bit ok;
    clear_logs();
    resp_hang = 1'b1;
    cfg_load = 32'd5; cfg_interval = 16'd1;
    vs0 = valid_starts;
    pulse_start();
    t = 0;
    while (drop_len == 0 && t < 100) begin @(negedge clk); t++; end
    total++;
    if (drop_len !== 8) begin bad++; $display("FAIL timeout_len: got %0d want 8", drop_len); end
    total++;
    if (bus_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout_flags: got err=%b busy=%b want err=1 busy=0", bus_err, busy);
    end
    repeat (10) @(negedge clk);
    total++;
    if (valid_starts !== vs0 + 1 || bus_err !== 1'b1) begin
      bad++; $display("FAIL timeout_no_stop: got %0d requests err=%b want %0d err=1", valid_starts - vs0, bus_err, 1);
    end
    resp_hang = 1'b0;
    pulse_start();
    total++;
    if (bus_err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL err_clear: got err=%b busy=%b want err=0 busy=1", bus_err, busy);
    end
    pulse_stop();
    wait_idle(200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timeout_restart_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_hit_stop_wait;
    bit ok;
    int n0;
    int l0;
    clear_logs();
    rd_val = 32'd10; rd_step = 32'hFFFF_FFFF;
    cfg_load = 32'd10; cfg_dir = 1'b0; cfg_interval = 16'd6; cfg_threshold = 32'd7;
    pulse_start();
    wait_samples(6, 500, ok);
    total++;
    if (!ok || log_wdata[1] !== 32'h1) begin
      bad++; $display("FAIL down_ctrl: got samples=%0d ctrl=%h want 6 ctrl=00000001", samp_n, log_wdata[1]);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (samp[k] !== 32'(10 - k) || samp_hit[k] !== (k >= 3)) begin
        bad++; $display("FAIL hit_seq[%0d]: got %0d hit=%b want %0d hit=%b", k, samp[k], samp_hit[k], 10 - k, k >= 3);
      end
    end
    n0 = samp_n; l0 = log_n;
    pulse_stop();
    wait_idle(100, ok);
    total++;
    if (!ok || samp_n !== n0 || log_n !== l0 + 1 || log_addr[log_n-1] !== BASE || log_wdata[log_n-1] !== 32'h0) begin
      bad++; $display("FAIL stop_in_wait: got idle=%b smp+%0d txn+%0d last=%h/%h want 1,+0,+1,%h/00000000",
                      ok, samp_n - n0, log_n - l0, log_addr[log_n-1], log_wdata[log_n-1], BASE);
    end
    total++;
    if (hit !== 1'b1 || sample !== rd_val + 32'd1) begin
      bad++; $display("FAIL held_after_stop: got hit=%b sample=%0d want hit=1 sample=%0d", hit, sample, rd_val + 32'd1);
    end
    cfg_threshold = 32'hFFFF_FFF0;
    pulse_start();
    total++;
    if (hit !== 1'b0) begin bad++; $display("FAIL hit_clear: got %b want 0", hit); end
    pulse_stop();
    wait_idle(200, ok);
  endtask

  task automatic test_stop_read;
    bit          ok;
    int          t;
    int          n0;
    logic [31:0] exp;
    clear_logs();
    resp_wait = 3; rd_val = 32'h0000_0700; rd_step = 32'd1;
    cfg_dir = 1'b1; cfg_interval = 16'd2; cfg_threshold = 32'd0;
    pulse_start();
    t = 0;
    while (!(mem_valid === 1'b1 && mem_wstrb === 4'h0) && t < 200) begin @(negedge clk); t++; end
    exp = rd_val; n0 = samp_n;
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(200, ok);
    total++;
    if (!ok || samp_n !== n0 + 1 || sample !== exp) begin
      bad++; $display("FAIL stop_mid_read: got idle=%b smp+%0d sample=%h want 1,+1,%h", ok, samp_n - n0, sample, exp);
    end
    total++;
    if (log_addr[log_n-1] !== BASE || log_wdata[log_n-1] !== 32'h0 || log_addr[log_n-2] !== BASE + 32'h8) begin
      bad++; $display("FAIL stop_read_seq: got %h/%h after %h want %h/00000000 after %h",
                      log_addr[log_n-1], log_wdata[log_n-1], log_addr[log_n-2], BASE, BASE + 32'h8);
    end
    resp_wait = 0;
  endtask

  task automatic test_reset_midtxn;
    bit ok;
    int t;
    clear_logs();
    resp_wait = 3;
    pulse_start();
    t = 0;
    while (mem_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_valid, busy, sample_valid, hit, bus_err, sample, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      bad++; $display("FAIL reset_midtxn: got v=%b busy=%b sample=%h addr=%h wd=%h want all 0",
                      mem_valid, busy, sample, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
    resp_wait = 0; rd_val = 32'd42; rd_step = 32'd1;
    cfg_load = 32'd77; cfg_interval = 16'd0;
    pulse_start();
    wait_samples(2, 200, ok);
    total++;
    if (!ok || log_addr[0] !== BASE + 32'h4 || log_wdata[0] !== 32'd77 || samp[0] !== 32'd42 || samp[1] !== 32'd43) begin
      bad++; $display("FAIL after_reset_run: got ok=%b %h/%0d samples %0d,%0d want 1 %h/77 samples 42,43",
                      ok, log_addr[0], log_wdata[0], samp[0], samp[1], BASE + 32'h4);
    end
    pulse_stop();
    wait_idle(100, ok);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_timeout();
    test_hit_stop_wait();
    test_stop_read();
    test_reset_midtxn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
